// File: rtl/shift_deserializer.sv
// shift_deserializer: serial-to-parallel frame assembler with a 2-entry output buffer.
// Frames start on sof (qualified by sin_vld); bit order is chosen per frame by dir.
// Optional feature macro: PARITY_EN -- adds one even-parity bit after the data bits.
// Words failing parity are dropped and raise the sticky perr flag.
module shift_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_vld,
  input  logic             sof,
  input  logic             dir,
  output logic [WIDTH-1:0] op,
  output logic             op_vld,
  input  logic             op_rdy,
  output logic             busy,
  output logic             ovf,
  output logic             perr
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1} state_t;
`endif

  state_t           state_r;
  logic [WIDTH-1:0] sreg_r;
  logic [CW-1:0]    count_r;
  logic             dir_r;

  logic [WIDTH-1:0] shifted_s;
  logic             last_bit_s;
  logic             push_s;
  logic [WIDTH-1:0] push_data_s;
  logic             pop_s;

  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] tail_r;
  logic             head_vld_r;
  logic             tail_vld_r;
  logic             ovf_r;

`ifdef PARITY_EN
  logic             perr_r;

  // True when the data bits plus the received parity bit have even parity.
  function automatic logic even_parity_ok(input logic [WIDTH-1:0] data, input logic pbit);
    even_parity_ok = ((^data) ^ pbit) == 1'b0;
  endfunction
`endif

  // Next shift-register value and push decision for the bit currently on sin.
  always_comb begin
    shifted_s   = {WIDTH{1'b0}};
    last_bit_s  = 1'b0;
    push_s      = 1'b0;
    push_data_s = {WIDTH{1'b0}};
    if (dir_r) begin
      shifted_s = {sin, sreg_r[WIDTH-1:1]};
    end else begin
      shifted_s = {sreg_r[WIDTH-2:0], sin};
    end
    last_bit_s = (count_r == CW'(WIDTH - 1));
`ifdef PARITY_EN
    push_data_s = sreg_r;
    if (sin_vld && !sof && (state_r == PARITY) && even_parity_ok(sreg_r, sin)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
`else
    push_data_s = shifted_s;
    if (sin_vld && !sof && (state_r == COLLECT) && last_bit_s) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
`endif
  end

  // Frame FSM: start/restart on sof, shift data bits, optionally check parity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      sreg_r  <= {WIDTH{1'b0}};
      count_r <= {CW{1'b0}};
      dir_r   <= 1'b0;
`ifdef PARITY_EN
      perr_r  <= 1'b0;
`endif
    end else if (sin_vld) begin
      if (sof) begin
        // The current bit becomes bit 1 of a fresh frame, whatever state we were in.
        state_r <= COLLECT;
        dir_r   <= dir;
        count_r <= CW'(1);
        if (dir) begin
          sreg_r <= {sin, {(WIDTH-1){1'b0}}};
        end else begin
          sreg_r <= {{(WIDTH-1){1'b0}}, sin};
        end
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= IDLE;
          end
          COLLECT: begin
            sreg_r <= shifted_s;
            if (last_bit_s) begin
`ifdef PARITY_EN
              state_r <= PARITY;
              count_r <= count_r + CW'(1);
`else
              state_r <= IDLE;
              count_r <= {CW{1'b0}};
`endif
            end else begin
              count_r <= count_r + CW'(1);
            end
          end
`ifdef PARITY_EN
          PARITY: begin
            state_r <= IDLE;
            count_r <= {CW{1'b0}};
            if (!even_parity_ok(sreg_r, sin)) begin
              perr_r <= 1'b1;
            end
          end
`endif
          default: begin
            state_r <= IDLE;
            count_r <= {CW{1'b0}};
          end
        endcase
      end
    end
  end

  assign pop_s = head_vld_r & op_rdy;

  // Two-entry output buffer: head feeds op directly, tail holds the second word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_r     <= {WIDTH{1'b0}};
      tail_r     <= {WIDTH{1'b0}};
      head_vld_r <= 1'b0;
      tail_vld_r <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      case ({push_s, pop_s})
        2'b11: begin
          // Simultaneous push and pop never overflows.
          if (tail_vld_r) begin
            head_r <= tail_r;
            tail_r <= push_data_s;
          end else begin
            head_r <= push_data_s;
          end
        end
        2'b10: begin
          if (!head_vld_r) begin
            head_r     <= push_data_s;
            head_vld_r <= 1'b1;
          end else if (!tail_vld_r) begin
            tail_r     <= push_data_s;
            tail_vld_r <= 1'b1;
          end else begin
            ovf_r <= 1'b1;
          end
        end
        2'b01: begin
          head_r     <= tail_r;
          head_vld_r <= tail_vld_r;
          tail_vld_r <= 1'b0;
        end
        default: begin
          head_vld_r <= head_vld_r;
        end
      endcase
    end
  end

  assign op     = head_r;
  assign op_vld = head_vld_r;
  assign busy   = (state_r != IDLE);
  assign ovf    = ovf_r;
`ifdef PARITY_EN
  assign perr   = perr_r;
`else
  assign perr   = 1'b0;
`endif

endmodule

// File: tb/tb_shift_deserializer.sv
// Scoreboard bench for shift_deserializer (WIDTH=4): the stimulus process pushes
// expected words into a queue, a monitor process pops and compares on each transfer.
module tb_shift_deserializer;

  logic       clk;
  logic       rst;
  logic       sin;
  logic       sin_vld;
  logic       sof;
  logic       dir;
  logic [3:0] op;
  logic       op_vld;
  logic       op_rdy;
  logic       busy;
  logic       ovf;
  logic       perr;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  shift_deserializer #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .sin(sin), .sin_vld(sin_vld), .sof(sof), .dir(dir),
    .op(op), .op_vld(op_vld), .op_rdy(op_rdy), .busy(busy), .ovf(ovf), .perr(perr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present one bit for one clock; returns #1 after the edge that consumed it.
  task automatic send_bit(input logic b, input logic s, input logic d);
    sin = b; sin_vld = 1'b1; sof = s; dir = d;
    @(posedge clk); #1;
    sin_vld = 1'b0; sof = 1'b0; sin = 1'b0;
  endtask

  // Data bits in order bits[3], bits[2], bits[1], bits[0]; sof on the first.
  task automatic send_data(input logic [3:0] bits, input logic d);
    send_bit(bits[3], 1'b1, d);
    send_bit(bits[2], 1'b0, d);
    send_bit(bits[1], 1'b0, d);
    send_bit(bits[0], 1'b0, d);
  endtask

  // Full frame; with PARITY_EN a correct even-parity bit is appended.
  task automatic send_frame(input logic [3:0] bits, input logic d);
    send_data(bits, d);
`ifdef PARITY_EN
    send_bit(^bits, 1'b0, 1'b0);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk(name, exp_q.size(), 0);
  endtask

  // Monitor: compare each transferred word, and check op holds while stalled.
  initial begin
    logic [3:0] held;
    logic       held_vld;
    logic [3:0] e;
    held_vld = 1'b0;
    held = 4'd0;
    forever begin
      @(negedge clk);
      if (rst && op_vld) begin
        if (op_rdy) begin
          held_vld = 1'b0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: got %b expected none (t=%0t)", op, $time);
          end else begin
            e = exp_q.pop_front();
            if (op !== e) begin
              errors++;
              $display("FAIL word: got %b expected %b (t=%0t)", op, e, $time);
            end
          end
        end else begin
          if (held_vld) begin
            checks++;
            if (op !== held) begin
              errors++;
              $display("FAIL op_stable: got %b expected %b (t=%0t)", op, held, $time);
            end
          end
          held = op;
          held_vld = 1'b1;
        end
      end else begin
        held_vld = 1'b0;
      end
    end
  end

  initial begin
    rst = 1'b0; sin = 1'b0; sin_vld = 1'b0; sof = 1'b0; dir = 1'b0; op_rdy = 1'b1;
    #12;
    chk("reset_op", op, 4'd0);
    chk("reset_op_vld", op_vld, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_ovf", ovf, 1'b0);
    chk("reset_perr", perr, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;

    // MSB-first 1,0,1,1 -> 1011, valid the cycle after the last bit
    exp_q.push_back(4'b1011);
    send_frame(4'b1011, 1'b0);
    chk("msb_first_vld", op_vld, 1'b1);
    chk("msb_first_op", op, 4'b1011);
    drain("drain_msb");

    // LSB-first 1,0,1,1 -> 1101
    exp_q.push_back(4'b1101);
    send_frame(4'b1011, 1'b1);
    drain("drain_lsb");

    // LSB-first 0,0,1,1 -> 1100
    exp_q.push_back(4'b1100);
    send_frame(4'b0011, 1'b1);
    drain("drain_lsb2");

    // Stray bit in IDLE ignored; gaps in sin_vld hold state. Bits 0,1,0,0 -> 0100
    send_bit(1'b1, 1'b0, 1'b0);
    chk("stray_busy", busy, 1'b0);
    exp_q.push_back(4'b0100);
    send_bit(1'b0, 1'b1, 1'b0);
    idle(2);
    chk("gap_busy", busy, 1'b1);
    send_bit(1'b1, 1'b0, 1'b0);
    idle(1);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
`ifdef PARITY_EN
    send_bit(1'b1, 1'b0, 1'b0);
`endif
    drain("drain_gap");

    // Restart: 1,1 then sof with 0,1,1,0 -> only 0110
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    exp_q.push_back(4'b0110);
    send_frame(4'b0110, 1'b0);
    drain("drain_restart");

    // Overflow: consumer stalled, third word dropped
    op_rdy = 1'b0;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    send_frame(4'b0001, 1'b0);
    send_frame(4'b0010, 1'b0);
    chk("full_ovf_clear", ovf, 1'b0);
    send_frame(4'b0011, 1'b0);
    chk("ovf_set", ovf, 1'b1);
    chk("ovf_head", op, 4'b0001);
    chk("ovf_vld", op_vld, 1'b1);
    idle(3);
    op_rdy = 1'b1;
    drain("drain_ovf");
    idle(1);
    chk("ovf_empty", op_vld, 1'b0);
    chk("ovf_sticky", ovf, 1'b1);

    // Asynchronous reset mid-frame
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    chk("mid_busy", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("arst_op_vld", op_vld, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_ovf", ovf, 1'b0);
    chk("arst_op", op, 4'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(4'b1001);
    send_frame(4'b1001, 1'b0);
    drain("drain_after_reset");

`ifdef PARITY_EN
    // Good parity bit: word delivered, perr stays 0
    exp_q.push_back(4'b1011);
    send_data(4'b1011, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    drain("drain_par_ok");
    chk("par_ok_perr", perr, 1'b0);
    // Bad parity bit: word dropped, perr set
    send_data(4'b1011, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    idle(3);
    chk("par_bad_perr", perr, 1'b1);
    chk("par_bad_vld", op_vld, 1'b0);
`else
    chk("perr_tied", perr, 1'b0);
`endif

    idle(5);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_deserializer.md
SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 Parameter: WIDTH, default 4, data bits per frame and width of op; legal range 2..16.
REQ-002 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low; asserted when 0.
REQ-004 Port: sin  input  1  serial data bit.
REQ-005 Port: sin_vld  input  1  sin is valid this cycle; bit consumed when 1.
REQ-006 Port: sof  input  1  start-of-frame; qualified by sin_vld; marks the first data bit.
REQ-007 Port: dir  input  1  bit order, sampled with sof: 0 = MSB-first (shift left), 1 = LSB-first (shift right).
REQ-008 Port: op  output  WIDTH  assembled word at head of output buffer.
REQ-009 Port: op_vld  output  1  op holds a word.
REQ-010 Port: op_rdy  input  1  consumer accepts op; pop when op_vld and op_rdy.
REQ-011 Port: busy  output  1  frame in progress (state not IDLE).
REQ-012 Port: ovf  output  1  sticky overflow flag.
REQ-013 Port: perr  output  1  sticky parity-error flag; constant 0 when PARITY_EN undefined.

Function
REQ-014 FSM states SHALL be IDLE, COLLECT, PARITY (PARITY exists only with PARITY_EN).
REQ-015 IDLE: sin_vld and sof -> capture sin as bit 1, latch dir, bit count = 1, go COLLECT; sin_vld without sof -> bit ignored.
REQ-016 COLLECT, sin_vld=1: dir=0 -> sreg = {sreg[WIDTH-2:0], sin}; dir=1 -> sreg = {sin, sreg[WIDTH-1:1]}; count increments.
REQ-017 sin_vld=0 in any state: sreg, count, state unchanged.
REQ-018 On acceptance of bit WIDTH: no PARITY_EN -> push word, go IDLE; PARITY_EN -> go PARITY.
REQ-019 sof with sin_vld in COLLECT or PARITY: discard partial frame, restart per REQ-015 with the current bit as bit 1; no flag raised.
REQ-020 Output buffer: 2-entry FIFO; op = head entry; op_vld = buffer not empty; words leave in arrival order.
REQ-021 Latency: op_vld rises the cycle after the final frame bit is accepted, when the buffer was empty.
REQ-022 Push while buffer full and no pop in the same cycle: word dropped, ovf set to 1.
REQ-023 Push and pop in the same cycle while full: both accepted; ovf unchanged.
REQ-024 op SHALL remain stable while op_vld=1 and op_rdy=0.
REQ-025 ovf and perr clear only on reset.

Reset
REQ-026 rst=0 SHALL immediately, without waiting for a clock, force state=IDLE, sreg=0, count=0, buffer empty, op=0, op_vld=0, busy=0, ovf=0, perr=0.
REQ-027 Reset mid-frame discards the partial frame; the first frame after rst=1 decodes normally.

Configuration
REQ-028 Macro PARITY_EN defined: one even-parity bit follows the WIDTH data bits; in PARITY, on sin_vld, parity of data plus the parity bit equal to 0 -> push word; otherwise drop word and set perr; then go IDLE.
REQ-029 Macro PARITY_EN undefined: no PARITY state; frame is exactly WIDTH bits; perr tied to 0.

Verification
REQ-030 WIDTH=4, dir=0, bits 1,0,1,1 (sof on first), op_rdy=1 -> op=4'b1011, op_vld high 1 cycle after last bit.
REQ-031 dir=1, bits 1,0,1,1 -> op=4'b1101.
REQ-032 op_rdy=0, frames 0001, 0010, 0011 -> first two held in order, third dropped, ovf=1; then op_rdy=1 -> pops 0001 then 0010.
REQ-033 dir=0, bits 1,1, then sof with bits 0,1,1,0 -> only op=4'b0110 delivered.
REQ-034 rst=0 after 2 bits of a frame -> op_vld=0, busy=0, ovf=0 at once; next frame 1,0,0,1 -> op=4'b1001.
REQ-035 PARITY_EN, bits 1,0,1,1: parity bit 1 -> op=4'b1011, perr=0; parity bit 0 -> no word, perr=1.
